// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage (master) and the data
// memory responder (slave).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. The master holds req_valid and the request fields
// steady until that edge; req_valid seen while req_ready is 0 has no effect.
// resp_valid is a one-cycle pulse with no back-pressure; resp_rdata and
// resp_err are meaningful only while resp_valid is 1.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [3:0]  req_web;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_read, req_web, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_read, req_web, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: single-port word array with byte write enables,
// read-before-write sampling into a response register and a one-cycle
// response pulse.
//
// Optional macro DMEM_WAIT_EN adds a WAIT state and a 4-bit down counter so
// the response arrives WAIT_CYCLES cycles later than in the default build.
// The current FSM state is exposed on dbg_state_o (IDLE=0, WAIT=1, RESP=2).
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [1:0]        dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  // Elaboration-time parameter legality
  if (DEPTH < 16 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two in 16..1024");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef DMEM_WAIT_EN
    S_WAIT = 2'd1,
`endif
    S_RESP = 2'd2
  } state_e;

  state_e         state_q;
  state_e         state_d;

  logic [31:0]    mem_q [DEPTH];
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic           err_q;

  logic           accept;
  logic           oor;
  logic [AW-1:0]  idx;

  // Byte bits [1:0] play no part in indexing; everything above the word
  // index must be zero for the address to hit the array.
  assign idx = bus.req_addr[AW+1:2];
  assign oor = |bus.req_addr[31:AW+2];

  // Accept only from IDLE and never on an edge that is resetting.
  assign accept = rst && bus.req_valid && (state_q == S_IDLE);

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt_q;

  // Wait counter: loaded on accept, counts down to zero while in WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      cnt_q <= 4'(WAIT_CYCLES - 1);
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef DMEM_WAIT_EN
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
`else
      S_IDLE: if (accept) state_d = S_RESP;
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state plus the held response register
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    dbg_state_o    = state_q;
  end

  // Load data for the response: the pre-write word, or zero for
  // out-of-range and non-load requests
  always_comb begin
    rdata_d = 32'h0;
    if (!oor && bus.req_read) begin
      rdata_d = mem_q[idx];
    end
  end

  // Response register: captured at accept, held until the next accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= rdata_d;
      err_q   <= oor;
    end
  end

  // Array write: byte lanes with active-low enables, in-range accepts only;
  // contents survive reset
  always_ff @(posedge clk) begin
    if (accept && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_web[i]) begin
          mem_q[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the data array (power of two, 16..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning added response wait states when DMEM_WAIT_EN is defined (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the memory-stage request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_read, input, 1, meaning the request is a load.
REQ-008 The block SHALL have port req_web, input, 4, meaning active-low byte write enables; bit i covers wdata[8i+7:8i]; 4'hf means no write.
REQ-009 The block SHALL have port req_addr, input, 32, meaning byte address; word index = req_addr[log2(DEPTH)+1:2].
REQ-010 The block SHALL have port req_wdata, input, 32, meaning store data, already byte-lane aligned.
REQ-011 The block SHALL have port resp_valid, output, 1, meaning a one-cycle response pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32, meaning the full load word, valid only while resp_valid=1.
REQ-013 The block SHALL have port resp_err, output, 1, meaning the address is out of range, valid only while resp_valid=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE, decoded from state.
REQ-015 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; cycle N is the accept cycle.
REQ-016 On accept, the word SHALL be sampled from the array before any write (read-before-write) into the response register.
REQ-017 On accept, each byte i with req_web[i]=0 SHALL be written in the same edge; bytes with req_web[i]=1 SHALL stay unchanged.
REQ-018 The address SHALL be out of range when any req_addr bit above log2(DEPTH)+1 is 1: no array write, rdata=0, err=1.
REQ-019 req_addr[1:0] SHALL be ignored for indexing; there is no misalignment error.
REQ-020 When req_read=0, resp_rdata SHALL be 32'h0; a write-only or no-op request (web=4'hf, read=0) SHALL still produce a response.
REQ-021 When req_read=1 and web!=4'hf, the write SHALL commit and rdata SHALL return the pre-write word.
REQ-022 Without DMEM_WAIT_EN, the FSM SHALL go IDLE to RESP on accept and RESP to IDLE unconditionally; resp_valid=1 in cycle N+1 only.
REQ-023 With DMEM_WAIT_EN, the FSM SHALL go IDLE to WAIT on accept, load a 4-bit counter with WAIT_CYCLES-1, and decrement it each cycle.
REQ-024 With DMEM_WAIT_EN, WAIT SHALL go to RESP when the counter is 0; resp_valid=1 in cycle N+1+WAIT_CYCLES only.
REQ-025 resp_valid SHALL be 0 in IDLE and WAIT; rdata and err SHALL hold their values outside RESP.
REQ-026 The maximum throughput SHALL be one request per 2 cycles without the macro and one per WAIT_CYCLES+2 cycles with it.
REQ-027 The next request SHALL be accepted at the earliest in the cycle after RESP.
REQ-028 req_valid while req_ready=0 SHALL be ignored and have no side effects; the requester holds it.

Reset
REQ-029 When rst=0 at a rising edge, the state SHALL become IDLE, resp_valid 0, resp_rdata 32'h0, resp_err 0 and the wait counter 0.
REQ-030 The array contents SHALL NOT be cleared by reset.
REQ-031 A reset during WAIT or RESP SHALL drop the pending response (no resp_valid afterwards); a write committed at accept SHALL persist.
REQ-032 No request SHALL be accepted on an edge where rst=0.

Configuration
REQ-033 Macro DMEM_WAIT_EN defined SHALL compile the WAIT state, the counter and the WAIT_CYCLES latency.
REQ-034 Macro DMEM_WAIT_EN undefined SHALL give fixed 1-cycle latency, with no counter and no WAIT state present.

Verification
REQ-035 Without the macro, write addr 0x10, wdata 0xDEADBEEF, web 4'h0, then read 0x10 -> first resp rdata 0, second resp rdata 0xDEADBEEF, each in cycle N+1.
REQ-036 Byte lanes: word 0x10=0xDEADBEEF, write 0x11223344 with web 4'b1010 -> a later read returns 0xDE22BE44.
REQ-037 Read+write together: word 0x20=0x0000AAAA, read=1, web=0, wdata 0x5555 -> rdata 0x0000AAAA, a later read returns 0x00005555.
REQ-038 Out of range (DEPTH=256): write addr 0x400, web 0 -> resp_err=1, rdata 0; a read of 0x0 returns the unchanged word.
REQ-039 DMEM_WAIT_EN, WAIT_CYCLES=2: accept at N -> req_ready 0 for cycles N+1..N+3, resp_valid only at N+3; req_valid held in between is ignored.
REQ-040 rst=0 in cycle N+1 after accepting a write to 0x30 -> no resp_valid afterwards; a later read of 0x30 returns the written data.
